// File: rtl/pico_io_pkg.sv
// Shared definitions for the PicoBlaze I/O peripherals: register offsets and
// the interrupt controller state encoding.
package pico_io_pkg;

    localparam logic [1:0] IRQ_OFS_PENDING = 2'd0;
    localparam logic [1:0] IRQ_OFS_MASK    = 2'd1;
    localparam logic [1:0] IRQ_OFS_CAUSE   = 2'd2;
    localparam logic [1:0] IRQ_OFS_MODE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2,
        SERVICE  = 2'd3
    } irq_state_t;

endpackage

// File: rtl/pico_irq_sync.sv
// Per-bit two-flop synchroniser for asynchronous interrupt sources.
module pico_irq_sync #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pico_irq_ctrl.sv
// PicoBlaze interrupt controller with a four-register I/O window.
// Define PICO_IRQ_SYNC_EN to put a two-flop synchroniser in front of irq_src.
module pico_irq_ctrl
    import pico_io_pkg::*;
#(
    parameter int         N_SRC     = 8,
    parameter logic [7:0] BASE_ADDR = 8'hE0
) (
    input  logic             clk,
    input  logic             cpu_reset,
    input  logic [7:0]       port_id,
    input  logic [7:0]       out_port,
    input  logic             write_strobe,
    input  logic             k_write_strobe,
    input  logic             read_strobe,
    input  logic             interrupt_ack,
    input  logic [N_SRC-1:0] irq_src,
    output logic             interrupt,
    output logic [7:0]       rd_data,
    output logic             busy
);

    irq_state_t       state_q, state_d;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] prev_q;
    logic             cause_valid_q, cause_valid_d;
    logic [2:0]       cause_idx_q, cause_idx_d;
    logic             interrupt_q, interrupt_d;
    logic [7:0]       rd_data_q, rd_data_d;

    logic [N_SRC-1:0] src_s;
    logic [N_SRC-1:0] set_vec;
    logic [N_SRC-1:0] elig;
    logic [N_SRC-1:0] win_oh;
    logic [N_SRC-1:0] ack_clr;
    logic [N_SRC-1:0] wr_clr;
    logic [2:0]       win_idx;
    logic             win_hit;
    logic             wr_en;
    logic             eoi;
    logic             unused_ok;

`ifdef PICO_IRQ_SYNC_EN
    pico_irq_sync #(.W(N_SRC)) u_sync (
        .clk_i (clk),
        .rst_i (cpu_reset),
        .d_i   (irq_src),
        .q_o   (src_s)
    );
`else
    assign src_s = irq_src;
`endif

    // INPUT data is returned whether or not read_strobe is present.
    assign unused_ok = read_strobe;

    assign win_hit = (port_id[7:2] == BASE_ADDR[7:2]);
    assign wr_en   = (write_strobe | k_write_strobe) & win_hit;
    assign eoi     = wr_en && (port_id[1:0] == IRQ_OFS_CAUSE);

    // Edge sources fire on 0->1 of the sampled input; level sources every high cycle.
    assign set_vec = (mode_q & src_s & ~prev_q) | (~mode_q & src_s);
    assign wr_clr  = (wr_en && (port_id[1:0] == IRQ_OFS_PENDING)) ? out_port[N_SRC-1:0] : '0;

    // A set in the same cycle as any clear wins because it is OR-ed in last.
    assign pending_d = (pending_q & ~(wr_clr | ack_clr)) | set_vec;
    assign mask_d    = (wr_en && (port_id[1:0] == IRQ_OFS_MASK)) ? out_port[N_SRC-1:0] : mask_q;
    assign mode_d    = (wr_en && (port_id[1:0] == IRQ_OFS_MODE)) ? out_port[N_SRC-1:0] : mode_q;

    assign elig   = pending_q & mask_q;
    assign win_oh = elig & (~elig + N_SRC'(1));

    always_comb begin
        win_idx = 3'd0;
        for (int i = 0; i < N_SRC; i++) begin
            if (win_oh[i]) win_idx = 3'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        cause_valid_d = cause_valid_q;
        cause_idx_d   = cause_idx_q;
        ack_clr       = '0;
        case (state_q)
            IDLE: begin
                if (|elig) state_d = REQ;
            end
            REQ: begin
                if (!(|elig)) begin
                    state_d = IDLE;
                end else if (interrupt_ack) begin
                    cause_valid_d = 1'b1;
                    cause_idx_d   = win_idx;
                    ack_clr       = win_oh;
                    state_d       = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                state_d = SERVICE;
            end
            SERVICE: begin
                if (eoi) begin
                    cause_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        interrupt_d = (state_d == REQ);
    end

    always_comb begin
        rd_data_d = 8'h00;
        if (win_hit) begin
            case (port_id[1:0])
                IRQ_OFS_PENDING: rd_data_d = 8'(pending_q);
                IRQ_OFS_MASK:    rd_data_d = 8'(mask_q);
                IRQ_OFS_CAUSE:   rd_data_d = {cause_valid_q, 4'b0000, cause_idx_q};
                IRQ_OFS_MODE:    rd_data_d = 8'(mode_q);
                default:         rd_data_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            mask_q        <= '0;
            mode_q        <= '0;
            prev_q        <= '0;
            cause_valid_q <= 1'b0;
            cause_idx_q   <= 3'd0;
            interrupt_q   <= 1'b0;
            rd_data_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            mask_q        <= mask_d;
            mode_q        <= mode_d;
            prev_q        <= src_s;
            cause_valid_q <= cause_valid_d;
            cause_idx_q   <= cause_idx_d;
            interrupt_q   <= interrupt_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign interrupt = interrupt_q;
    assign rd_data   = rd_data_q;
    assign busy      = (state_q == WAIT_ACK) || (state_q == SERVICE);

endmodule

// File: doc/pico_irq_ctrl.md
# pico_irq_ctrl

Interrupt controller and register window for the PicoBlaze core inside `pico_top`. It collects up to `N_SRC` peripheral interrupt sources and latches them as pending. It masks and prioritises the pending sources, drives the single `interrupt` input of the processor, and tracks the `interrupt_ack` / end-of-interrupt handshake. Software reaches its status and control registers through the processor's `port_id`/`in_port`/`out_port` I/O bus.

## Interface
Parameters:
- `N_SRC`, 8 — number of interrupt sources (1..8).
- `BASE_ADDR`, 8'hE0 — port_id of register 0; the block decodes `BASE_ADDR`..`BASE_ADDR+3`. `BASE_ADDR[1:0]` must be 0.

Ports (single clock `clk`; reset `cpu_reset` is asynchronous, active-high):
- `clk` input 1 — system clock.
- `cpu_reset` input 1 — asynchronous active-high reset.
- `port_id` input 8 — processor I/O address.
- `out_port` input 8 — processor write data.
- `write_strobe` input 1 — OUTPUT strobe.
- `k_write_strobe` input 1 — OUTPUTK strobe; treated identically to `write_strobe`.
- `read_strobe` input 1 — INPUT strobe.
- `interrupt_ack` input 1 — processor acknowledge pulse.
- `irq_src` input N_SRC — peripheral interrupt requests.
- `interrupt` output 1 — interrupt request to the processor.
- `rd_data` output 8 — registered read data, to be OR-ed into `in_port`.
- `busy` output 1 — high while in WAIT_ACK or SERVICE.

## Operation
- Register map (offsets from BASE_ADDR):
  - 0 PENDING: read returns pending bits. Writing 1 to a bit clears it; writing 0 has no effect.
  - 1 MASK: read/write. Bit=1 enables the source.
  - 2 CAUSE: read returns {valid, 4'b0, index[2:0]}. Any write is EOI.
  - 3 MODE: read/write. Bit=1 selects rising-edge capture; bit=0 selects level.
- Unused upper bits read 0. Writes to them are ignored.
- Capture:
  - Edge source: the pending bit sets when prev=0 and cur=1.
  - Level source: the pending bit sets every cycle the source is high.
  - A set and a clear in the same cycle: the set wins. A level source still high therefore stays pending.
- Priority: among `pending & mask`, the lowest index wins.
- FSM:
  - IDLE: if any `pending & mask` bit is set, go to REQ.
  - REQ: `interrupt`=1. On `interrupt_ack`:
    - latch the winning index into CAUSE with valid=1;
    - clear that pending bit, unless the set-wins rule applies;
    - go to WAIT_ACK.
  - WAIT_ACK: stay one cycle, then go to SERVICE.
  - SERVICE: `interrupt`=0. An EOI write clears CAUSE.valid and returns to IDLE.
- New requests during WAIT_ACK or SERVICE are latched as pending and not signalled.
- If MASK is cleared while in REQ so that nothing remains eligible, return to IDLE and drop `interrupt`. No ack is expected.
- An `interrupt_ack` outside REQ is ignored.
- An EOI write outside SERVICE is ignored; it does not change CAUSE.
- Reset values:
  - PENDING=0, MASK=0, MODE=0, CAUSE=0;
  - prev-sample flops=0;
  - state=IDLE;
  - `interrupt`=0, `rd_data`=0, `busy`=0.
- Reset mid-operation returns to IDLE immediately (asynchronously). No interrupt is re-signalled until the source re-asserts after reset.

## Timing
- `irq_src` rising in cycle t, source unmasked, state IDLE:
  - PENDING bit visible at edge t+1;
  - REQ entered at edge t+2;
  - `interrupt` high from edge t+2.
- `interrupt` is registered. It stays high until the cycle after `interrupt_ack` is sampled.
- Read:
  - `rd_data` updates on the edge after a cycle with `port_id` in the window;
  - `read_strobe` is not required for data;
  - `rd_data`=0 when `port_id` is outside the window.
- Write: takes effect on the edge where the strobe is sampled high with a matching `port_id`.
- EOI: IDLE is reached on the same edge as the EOI write. A still-pending masked source raises `interrupt` 2 edges later.

## Configuration
- `PICO_IRQ_SYNC_EN`:
  - Defined: each `irq_src` bit passes through a two-flop synchroniser before capture. All source-to-`interrupt` latencies grow by 2 cycles (t+4). Synchroniser flops reset to 0.
  - Undefined: `irq_src` is sampled directly. Sources must be synchronous to `clk`.

## Structure
- Package `pico_io_pkg`:
  - register offset constants `IRQ_OFS_PENDING`, `IRQ_OFS_MASK`, `IRQ_OFS_CAUSE`, `IRQ_OFS_MODE`;
  - FSM state enum `irq_state_t` {IDLE, REQ, WAIT_ACK, SERVICE}.
- Sub-module `pico_irq_sync`: a per-bit two-flop synchroniser, instantiated only under `PICO_IRQ_SYNC_EN`. The priority encoder and FSM stay in the top module.

## Test plan
- Reset, then read offsets 0–3 → 8'h00 each; `interrupt`=0.
- Write MASK=8'h05 and MODE=8'h01. Pulse `irq_src[0]` for 1 cycle → `interrupt` high at t+2. Pulse `interrupt_ack` → CAUSE reads 8'h80, PENDING reads 8'h00. EOI write → back to IDLE.
- With MASK=8'h06, raise `irq_src[1]` and `irq_src[2]` together (edge mode) → CAUSE=8'h81 first. After EOI, `interrupt` re-asserts within 2 cycles → CAUSE=8'h82.
- Hold level source `irq_src[3]` high with MASK=8'h08 and write PENDING=8'h08 → bit 3 still reads 1 (set-wins). After ack and EOI, `interrupt` re-asserts.
- Raise `irq_src[4]` while in SERVICE → PENDING bit 4=1, `interrupt` stays 0 until EOI.
- Assert `cpu_reset` while in REQ → `interrupt`=0 without waiting for a clock edge; all registers read 0 after release.
